// File: rtl/ayatsuki_dmem_wbuf.sv
// ayatsuki_dmem_wbuf: data-memory responder for the AyaTsuki core.
// Fronts a single-port synchronous SRAM with a posted-write FIFO so reads
// never wait behind writes; reads that hit a pending write are forwarded
// from the youngest matching entry. Reads have priority over the drain.
// Optional build macro: AYATSUKI_WBUF_MERGE_EN (merge writes into a
// matching pending entry instead of allocating a new one).
module ayatsuki_dmem_wbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 14,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_enable_i,
    input  logic              mem_w_enable_i,
    input  logic              mem_r_enable_i,
    input  logic [ADDR_W-1:0] mem_w_addr_i,
    input  logic [ADDR_W-1:0] mem_r_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              busy_o,
    output logic              ovf_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Buffer storage and FIFO bookkeeping
    logic [RAM_AW-1:0] r_baddr [DEPTH];
    logic [DATA_W-1:0] r_bdata [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_ovf;

    // Read-return state: r_rd_sram selects the SRAM output, otherwise r_hold
    logic              r_rd_sram;
    logic [DATA_W-1:0] r_hold;

    logic [RAM_AW-1:0] w_rd_word;
    logic [RAM_AW-1:0] w_wr_word;
    logic              w_rd;
    logic              w_wr;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_mrg_hit;
    logic [DATA_W-1:0] w_data_out;
    logic              w_unused;

    // Byte-lane bits are ignored: word accesses only
    assign w_unused  = &{1'b0, mem_r_addr_i[1:0], mem_w_addr_i[1:0]};

    assign w_rd_word = mem_r_addr_i[RAM_AW+1:2];
    assign w_wr_word = mem_w_addr_i[RAM_AW+1:2];
    assign w_rd      = mem_r_enable_i && (mem_r_addr_i[ADDR_W-1:RAM_AW+2] == '0);
    assign w_wr      = mem_enable_i && mem_w_enable_i &&
                       (mem_w_addr_i[ADDR_W-1:RAM_AW+2] == '0);

    // The drain only gets the SRAM in cycles without a read
    assign w_pop  = !w_rd && (r_cnt != '0);
    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_push = w_wr && !w_mrg_hit && (!w_full || w_pop);
    assign w_drop = w_wr && !w_mrg_hit && w_full && !w_pop;

    // Forward lookup: scan oldest to youngest so the youngest match wins
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_cnt) && (r_baddr[r_rp + PW'(i)] == w_rd_word)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_bdata[r_rp + PW'(i)];
            end
        end
    end

`ifdef AYATSUKI_WBUF_MERGE_EN
    logic [PW-1:0] w_mrg_idx;

    // Merge lookup; the head entry is excluded when it is being drained now,
    // otherwise the new data would be lost with the outgoing SRAM write
    always_comb begin
        w_mrg_hit = 1'b0;
        w_mrg_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_cnt) && !((i == 0) && w_pop) &&
                (r_baddr[r_rp + PW'(i)] == w_wr_word)) begin
                w_mrg_hit = w_wr;
                w_mrg_idx = r_rp + PW'(i);
            end
        end
    end

    // Entry payload: allocate on push, overwrite in place on merge
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_baddr[r_wp] <= w_wr_word;
            r_bdata[r_wp] <= mem_data_i;
        end else if (w_mrg_hit) begin
            r_bdata[w_mrg_idx] <= mem_data_i;
        end
    end
`else
    assign w_mrg_hit = 1'b0;

    // Entry payload: every accepted write allocates a new slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_baddr[r_wp] <= w_wr_word;
            r_bdata[r_wp] <= mem_data_i;
        end
    end
`endif

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Status flags: busy follows the registered count, overflow is sticky
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_busy <= (r_cnt >= CW'(DEPTH - 1));
            r_ovf  <= r_ovf | w_drop;
        end
    end

    // Read return: forwarded or zero data is latched, SRAM data passes through
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_sram <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_rd_sram <= w_rd && !w_fwd_hit;
            if (mem_r_enable_i && !w_rd)
                r_hold <= '0;
            else if (w_rd && w_fwd_hit)
                r_hold <= w_fwd_data;
            else
                r_hold <= w_data_out;
        end
    end

    assign w_data_out = r_rd_sram ? ram_rdata_i : r_hold;
    assign mem_data_o = w_data_out;
    assign busy_o     = r_busy;
    assign ovf_o      = r_ovf;

    // SRAM port: gated by reset so an in-flight drain write is suppressed
    assign ram_en_o    = rst_n && (w_rd || w_pop);
    assign ram_we_o    = rst_n && w_pop;
    assign ram_addr_o  = !rst_n ? '0 :
                         w_rd   ? w_rd_word :
                         w_pop  ? r_baddr[r_rp] : '0;
    assign ram_wdata_o = (rst_n && w_pop) ? r_bdata[r_rp] : '0;

endmodule

// File: tb/tb_ayatsuki_dmem_wbuf.sv
// Testbench for ayatsuki_dmem_wbuf: directed scenarios followed by random
// traffic, checked against an architectural memory model plus a queue
// model of buffer occupancy. Honours AYATSUKI_WBUF_MERGE_EN if defined.
module tb_ayatsuki_dmem_wbuf;

    localparam int DEPTH = 4;
    localparam int WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_enable_i = 1'b0;
    logic        mem_w_enable_i = 1'b0;
    logic        mem_r_enable_i = 1'b0;
    logic [31:0] mem_w_addr_i = '0;
    logic [31:0] mem_r_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        ovf_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;

    logic [31:0] sram    [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [13:0] mq [$];
    logic [31:0] exp_data = '0;
    logic        exp_busy = 1'b0;
    logic        exp_ovf  = 1'b0;
    int          checks = 0;
    int          errors = 0;

    ayatsuki_dmem_wbuf #(.ADDR_W(32), .DATA_W(32), .RAM_AW(14), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_enable_i(mem_enable_i), .mem_w_enable_i(mem_w_enable_i),
        .mem_r_enable_i(mem_r_enable_i), .mem_w_addr_i(mem_w_addr_i),
        .mem_r_addr_i(mem_r_addr_i), .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o), .busy_o(busy_o), .ovf_o(ovf_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM model
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) sram[ram_addr_o] <= ram_wdata_o;
            else          ram_rdata_i <= sram[ram_addr_o];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of traffic. mode 1: SRAM must not be written this cycle;
    // mode 2: SRAM must not be enabled this cycle.
    task automatic step(input bit re, input logic [31:0] ra, input bit we,
                        input logic [31:0] wa, input logic [31:0] wd, input int mode);
        bit          rd_in, wr_in, pop, merged;
        logic [13:0] rw, ww;
        logic        busy_next;
        @(negedge clk);
        mem_r_enable_i = re;   mem_r_addr_i = ra;
        mem_enable_i   = we;   mem_w_enable_i = we;
        mem_w_addr_i   = wa;   mem_data_i = wd;
        #1;
        if (mode == 1) check("no_sram_write", {31'd0, ram_we_o}, 32'd0);
        if (mode == 2) check("no_sram_access", {31'd0, ram_en_o}, 32'd0);

        rd_in = (ra < 32'h0001_0000);
        wr_in = (wa < 32'h0001_0000);
        rw = ra[15:2];
        ww = wa[15:2];
        busy_next = (mq.size() >= DEPTH - 1);
        if (re) exp_data = rd_in ? ref_mem[rw] : 32'd0;
        pop = !(re && rd_in) && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (we && wr_in) begin
            merged = 1'b0;
`ifdef AYATSUKI_WBUF_MERGE_EN
            foreach (mq[i]) if (mq[i] == ww) merged = 1'b1;
`endif
            if (merged) ref_mem[ww] = wd;
            else if (mq.size() < DEPTH) begin
                mq.push_back(ww);
                ref_mem[ww] = wd;
            end else exp_ovf = 1'b1;
        end
        exp_busy = busy_next;

        @(posedge clk);
        #1;
        check("read_data", mem_data_o, exp_data);
        check("busy", {31'd0, busy_o}, {31'd0, exp_busy});
        check("ovf", {31'd0, ovf_o}, {31'd0, exp_ovf});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) a = 32'h0001_0000 + $urandom_range(0, 255);
        else a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", mem_data_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ovf", {31'd0, ovf_o}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en_o}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
        check("rst_ram_addr", {18'd0, ram_addr_o}, 32'd0);
        check("rst_ram_wdata", ram_wdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write, let it drain, read back through the SRAM
        step(1'b0, 32'd0, 1'b1, 32'h0, 32'h1122_3344, 0);
        idle(2);
        step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 0);
        check("t1_read", mem_data_o, 32'h1122_3344);

        // Drain blocked by back-to-back reads; data comes from forwarding
        step(1'b0, 32'd0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h10, 1'b0, 32'd0, 32'd0, 1);
        check("t2_fwd", mem_data_o, 32'hDEAD_BEEF);
        idle(2);

        // Same-cycle write and read see the old value; next read sees the new one
        step(1'b1, 32'h20, 1'b1, 32'h20, 32'hA5A5_A5A5, 0);
        check("t3_old", mem_data_o, 32'd0);
        step(1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 0);
        check("t3_new", mem_data_o, 32'hA5A5_A5A5);
        idle(3);

        // Fill the buffer behind continuous reads; the 5th write overflows
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h100, 1'b1, 32'(k * 4), 32'h5000_0000 + 32'(k), 1);
        check("t4_busy", {31'd0, busy_o}, 32'd1);
        check("t4_ovf", {31'd0, ovf_o}, 32'd1);
        idle(DEPTH + 2);
        step(1'b1, 32'h10, 1'b0, 32'd0, 32'd0, 0);
        check("t4_dropped", mem_data_o, 32'hDEAD_BEEF);

        // Repeated writes to one word behind continuous reads
        for (int k = 1; k <= 5; k++)
            step(1'b1, 32'h100, 1'b1, 32'h40, 32'(k), 1);
`ifdef AYATSUKI_WBUF_MERGE_EN
        check("t5_busy_merge", {31'd0, busy_o}, 32'd0);
`endif
        idle(DEPTH + 2);
        step(1'b1, 32'h40, 1'b0, 32'd0, 32'd0, 0);
`ifdef AYATSUKI_WBUF_MERGE_EN
        check("t5_merged", mem_data_o, 32'd5);
`else
        check("t5_youngest", mem_data_o, 32'd4);
`endif

        // Out-of-range read: no SRAM access, data returns zero
        step(1'b1, 32'h0001_0000, 1'b0, 32'd0, 32'd0, 2);
        check("t6_oor", mem_data_o, 32'd0);

        // Reset with two writes pending: nothing reaches the SRAM
        step(1'b1, 32'h0, 1'b1, 32'h800, 32'hCAFE_0001, 0);
        step(1'b1, 32'h0, 1'b1, 32'h804, 32'hCAFE_0002, 0);
        @(negedge clk);
        rst_n = 1'b0;
        mem_r_enable_i = 1'b0; mem_enable_i = 1'b0; mem_w_enable_i = 1'b0;
        #1;
        check("t7_rst_ram_en", {31'd0, ram_en_o}, 32'd0);
        check("t7_rst_ram_we", {31'd0, ram_we_o}, 32'd0);
        check("t7_rst_ram_addr", {18'd0, ram_addr_o}, 32'd0);
        check("t7_rst_ram_wdata", ram_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        mq.delete();
        ref_mem[14'h200] = '0;
        ref_mem[14'h201] = '0;
        exp_data = '0; exp_busy = 1'b0; exp_ovf = 1'b0;
        check("t7_data", mem_data_o, 32'd0);
        check("t7_busy", {31'd0, busy_o}, 32'd0);
        check("t7_ovf", {31'd0, ovf_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1);
        step(1'b1, 32'h800, 1'b0, 32'd0, 32'd0, 0);
        check("t7_discarded", mem_data_o, 32'd0);

        // Random traffic against the reference model
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 2) != 0, pick_addr(), $urandom_range(0, 1) == 1,
                 pick_addr(), $urandom(), 0);

        // Drain everything and compare the SRAM image with the model
        idle(DEPTH + 2);
        for (int w = 0; w < 32; w++)
            check($sformatf("sram_w%0d", w), sram[w], ref_mem[w]);
        check("sram_w200", sram[14'h200], ref_mem[14'h200]);
        check("sram_w201", sram[14'h201], ref_mem[14'h201]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
